// File: rtl/led_mode_ctrl_pkg.sv
// rtl/led_mode_ctrl_pkg.sv - shared mode encodings and LED seed patterns
//
// Purpose: pattern identifiers and the LED value each pattern starts from.
// LED vectors are active-low: a 0 bit lights the LED.
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L = 2'd0,
    MODE_ROT_R = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PONG  = 2'd3
  } mode_t;

  localparam logic [3:0] LED_OFF    = 4'b1111;
  localparam logic [3:0] SEED_ROT_L = 4'b1110;
  localparam logic [3:0] SEED_ROT_R = 4'b0111;
  localparam logic [3:0] SEED_BLINK = 4'b0000;
  localparam logic [3:0] SEED_PONG  = 4'b1110;

  function automatic logic [3:0] mode_seed(input mode_t m);
    logic [3:0] s;
    s = LED_OFF;
    case (m)
      MODE_ROT_L: s = SEED_ROT_L;
      MODE_ROT_R: s = SEED_ROT_R;
      MODE_BLINK: s = SEED_BLINK;
      MODE_PONG:  s = SEED_PONG;
      default:    s = LED_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// rtl/led_mode_ctrl_key_debounce.sv - push-button synchronizer, debouncer and press pulse
//
// Purpose: turn the raw bouncing key into a clean level and a single-cycle
// press pulse on each debounced 1->0 edge.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   key_n     raw push button, active-low, asynchronous
//   key_level debounced key level (1 = released)
//   press     one-cycle pulse on a debounced press
module key_debounce #(
  parameter logic [19:0] DEB_MAX = 20'd999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        armed;
  logic [19:0] cnt;

  // After reset the debouncer is disarmed: it silently adopts whatever level
  // the key settles to, so a button held through reset never yields a press.
  // It arms once the key has been seen stably released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      key_level <= 1'b1;
      armed     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (!armed) begin
        // Count cycles of a stable synced level, whatever it is.
        if (sync1 != sync2) begin
          cnt <= '0;
        end else if (cnt == DEB_MAX) begin
          cnt       <= '0;
          key_level <= sync2;
          armed     <= sync2;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == DEB_MAX) begin
        cnt       <= '0;
        key_level <= sync2;
        press     <= ~sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - 4-LED pattern sequencer with push-button mode select
//
// Purpose: step one of four LED patterns on a periodic tick; each debounced
// key press advances to the next pattern and restarts it from its seed.
// Ports:
//   clk    system clock (50 MHz)
//   rst    asynchronous active-low reset
//   key_n  raw push button, active-low
//   led    LED drive, active-low, registered
//   mode   current pattern: 0 ROT_L, 1 ROT_R, 2 BLINK, 3 PONG
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter logic [24:0] CNT_MAX = 25'd24_999_999,
  parameter logic [19:0] DEB_MAX = 20'd999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic [3:0] led,
  output logic [1:0] mode
);

  logic [24:0] cnt_q, cnt_d;
  mode_t       mode_q, mode_d;
  logic [3:0]  led_q, led_d;
  logic        dir_q, dir_d;   // PONG direction: 0 toward bit 3, 1 toward bit 0
  logic        tick;
  logic        press;
  logic        key_level_unused;

  key_debounce #(.DEB_MAX(DEB_MAX)) u_key (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_level (key_level_unused),
    .press     (press)
  );

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      mode_q <= MODE_ROT_L;
      led_q  <= SEED_ROT_L;
      dir_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
    end
  end

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 25'd1;
    mode_d = mode_q;
    led_d  = led_q;
    dir_d  = dir_q;
    // A press outranks a coincident tick and restarts the step period.
    if (press) begin
      mode_d = mode_t'(mode_q + 2'd1);
      led_d  = mode_seed(mode_d);
      dir_d  = 1'b0;
      cnt_d  = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_ROT_L: led_d = {led_q[2:0], led_q[3]};
        MODE_ROT_R: led_d = {led_q[0], led_q[3:1]};
        MODE_BLINK: led_d = ~led_q;
        MODE_PONG: begin
          // Shifts fill with 1 so exactly one LED stays lit; turn around
          // as soon as the lit bit lands on an end.
          if (!dir_q) begin
            led_d = {led_q[2:0], 1'b1};
            if (!led_d[3]) dir_d = 1'b1;
          end else begin
            led_d = {1'b1, led_q[3:1]};
            if (!led_d[0]) dir_d = 1'b0;
          end
        end
        default: led_d = LED_OFF;
      endcase
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
